// File: rtl/mux2_arb_pkg.sv
// ------------------------------------------------------------------
// mux2_arb_pkg: state encoding and select constants for mux2_rr_arbiter
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package mux2_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      OWN_A = 2'b01,
      OWN_B = 2'b10,
      GAP   = 2'b11
   } arb_state_t;

   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

endpackage

`default_nettype wire

// File: rtl/mux2_arb_hold_cnt.sv
// ------------------------------------------------------------------
// mux2_arb_hold_cnt: saturating 8-bit grant-hold counter, flags HOLD-1
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module mux2_arb_hold_cnt #(
   parameter int HOLD = 4
) (
   input  logic clk,
   input  logic rst_l,
   input  logic clr,
   input  logic inc,
   output logic at_limit
);

   localparam logic [7:0] LIMIT = 8'(HOLD - 1);

   logic [7:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_l) begin
         cnt <= 8'd0;
      end else if (clr) begin
         cnt <= 8'd0;
      end else if (inc && !at_limit) begin
         cnt <= cnt + 8'd1;
      end
   end

   assign at_limit = (cnt == LIMIT);

endmodule

`default_nettype wire

// File: rtl/mux2_rr_arbiter.sv
// ------------------------------------------------------------------
// mux2_rr_arbiter: round-robin owner FSM driving SEL/EN_L of a 2:1 gated mux;
// define MUX2_ARB_GAP_EN to insert a dead cycle on every handover. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module mux2_rr_arbiter
   import mux2_arb_pkg::*;
#(
   parameter int HOLD = 4
) (
   input  logic CLK,
   input  logic RST_L,
   input  logic REQ_A,
   input  logic REQ_B,
   output logic SEL,
   output logic EN_L,
   output logic GNT_A,
   output logic GNT_B
);

`ifdef MUX2_ARB_GAP_EN
   localparam arb_state_t HAND_TO_A = GAP;
   localparam arb_state_t HAND_TO_B = GAP;
`else
   localparam arb_state_t HAND_TO_A = OWN_A;
   localparam arb_state_t HAND_TO_B = OWN_B;
`endif

   arb_state_t state, state_nxt;
   logic       last, last_nxt;
   logic       sel_q, en_l_q, gnt_a_q, gnt_b_q;
   logic       sel_nxt, en_l_nxt, gnt_a_nxt, gnt_b_nxt;
   logic       owning_nxt, cnt_clr, cnt_inc, at_limit;

   mux2_arb_hold_cnt #(
      .HOLD (HOLD)
   ) u_hold_cnt (
      .clk      (CLK),
      .rst_l    (RST_L),
      .clr      (cnt_clr),
      .inc      (cnt_inc),
      .at_limit (at_limit)
   );

   // State and output registers; outputs are pre-decoded from state_nxt
   always_ff @(posedge CLK) begin
      if (!RST_L) begin
         state   <= IDLE;
         last    <= 1'b1;
         sel_q   <= SEL_A;
         en_l_q  <= 1'b1;
         gnt_a_q <= 1'b0;
         gnt_b_q <= 1'b0;
      end else begin
         state   <= state_nxt;
         last    <= last_nxt;
         sel_q   <= sel_nxt;
         en_l_q  <= en_l_nxt;
         gnt_a_q <= gnt_a_nxt;
         gnt_b_q <= gnt_b_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (REQ_A && REQ_B) state_nxt = (last == SEL_B) ? OWN_A : OWN_B;
            else if (REQ_A)     state_nxt = OWN_A;
            else if (REQ_B)     state_nxt = OWN_B;
         end
         OWN_A: begin
            if (!REQ_A)                state_nxt = REQ_B ? HAND_TO_B : IDLE;
            else if (at_limit && REQ_B) state_nxt = HAND_TO_B;
         end
         OWN_B: begin
            if (!REQ_B)                state_nxt = REQ_A ? HAND_TO_A : IDLE;
            else if (at_limit && REQ_A) state_nxt = HAND_TO_A;
         end
         GAP: begin
            // Prefer whoever did not own before the gap
            if (last == SEL_A) begin
               if (REQ_B)      state_nxt = OWN_B;
               else if (REQ_A) state_nxt = OWN_A;
               else            state_nxt = IDLE;
            end else begin
               if (REQ_A)      state_nxt = OWN_A;
               else if (REQ_B) state_nxt = OWN_B;
               else            state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      owning_nxt = (state_nxt == OWN_A) || (state_nxt == OWN_B);
      cnt_clr    = owning_nxt && (state_nxt != state);
      cnt_inc    = owning_nxt && (state_nxt == state);

      last_nxt = last;
      if (state_nxt == OWN_A) last_nxt = SEL_A;
      if (state_nxt == OWN_B) last_nxt = SEL_B;

      gnt_a_nxt = (state_nxt == OWN_A);
      gnt_b_nxt = (state_nxt == OWN_B);
      en_l_nxt  = !owning_nxt;
      sel_nxt   = sel_q;
      if (gnt_a_nxt) sel_nxt = SEL_A;
      if (gnt_b_nxt) sel_nxt = SEL_B;
   end

   assign SEL   = sel_q;
   assign EN_L  = en_l_q;
   assign GNT_A = gnt_a_q;
   assign GNT_B = gnt_b_q;

endmodule

`default_nettype wire

// File: tb/tb_mux2_rr_arbiter.sv
// ------------------------------------------------------------------
// tb_mux2_rr_arbiter: directed vector table plus a mid-grant reset sequence
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_mux2_rr_arbiter;

   localparam int HOLD = 4;

   // Packed output view {GNT_A, GNT_B, EN_L, SEL}
   localparam logic [3:0] O_IDLE0 = 4'b0010;
   localparam logic [3:0] O_IDLE1 = 4'b0011;
   localparam logic [3:0] O_A     = 4'b1000;
   localparam logic [3:0] O_B     = 4'b0101;

   logic CLK = 1'b0;
   logic RST_L = 1'b0;
   logic REQ_A = 1'b0;
   logic REQ_B = 1'b0;
   logic SEL, EN_L, GNT_A, GNT_B;

   int total  = 0;
   int passed = 0;

   typedef struct {
      logic       rst_l;
      logic       req_a;
      logic       req_b;
      logic [3:0] exp;
   } vec_t;

   vec_t vecs[$];

   always #5 CLK = ~CLK;

   mux2_rr_arbiter #(
      .HOLD (HOLD)
   ) dut (
      .CLK   (CLK),
      .RST_L (RST_L),
      .REQ_A (REQ_A),
      .REQ_B (REQ_B),
      .SEL   (SEL),
      .EN_L  (EN_L),
      .GNT_A (GNT_A),
      .GNT_B (GNT_B)
   );

   function automatic void add(logic r, logic a, logic b, logic [3:0] e);
      vec_t v;
      v.rst_l = r;
      v.req_a = a;
      v.req_b = b;
      v.exp   = e;
      vecs.push_back(v);
   endfunction

   task automatic step(logic r, logic a, logic b);
      RST_L = r;
      REQ_A = a;
      REQ_B = b;
      @(posedge CLK);
      #1;
   endtask

   task automatic check(string name, int idx, logic [3:0] exp);
      logic [3:0] act;
      act = {GNT_A, GNT_B, EN_L, SEL};
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s[%0d]: {gnt_a,gnt_b,en_l,sel} got %b expected %b", name, idx, act, exp);
   endtask

   initial begin
      // Reset held with both requesting, then contention from release
      add(1'b0, 1'b1, 1'b1, O_IDLE0);
      add(1'b0, 1'b1, 1'b1, O_IDLE0);
`ifdef MUX2_ARB_GAP_EN
      for (int i = 0; i < 4; i++) add(1'b1, 1'b1, 1'b1, O_A);
      add(1'b1, 1'b1, 1'b1, O_IDLE0);
      for (int i = 0; i < 4; i++) add(1'b1, 1'b1, 1'b1, O_B);
      add(1'b1, 1'b1, 1'b1, O_IDLE1);
      for (int i = 0; i < 2; i++) add(1'b1, 1'b1, 1'b1, O_A);
`else
      for (int i = 0; i < 4; i++) add(1'b1, 1'b1, 1'b1, O_A);
      for (int i = 0; i < 4; i++) add(1'b1, 1'b1, 1'b1, O_B);
      for (int i = 0; i < 4; i++) add(1'b1, 1'b1, 1'b1, O_A);
`endif
      // Single requester holds past HOLD indefinitely
      add(1'b0, 1'b0, 1'b0, O_IDLE0);
      for (int i = 0; i < 20; i++) add(1'b1, 1'b1, 1'b0, O_A);
      // Early release to IDLE, then B; SEL holds 1 when B releases
      add(1'b0, 1'b0, 1'b0, O_IDLE0);
      add(1'b1, 1'b1, 1'b0, O_A);
      add(1'b1, 1'b1, 1'b0, O_A);
      add(1'b1, 1'b0, 1'b0, O_IDLE0);
      add(1'b1, 1'b0, 1'b1, O_B);
      add(1'b1, 1'b0, 1'b0, O_IDLE1);
      // Owner drops while the other side requests
      add(1'b0, 1'b0, 1'b0, O_IDLE0);
      add(1'b1, 1'b1, 1'b0, O_A);
`ifdef MUX2_ARB_GAP_EN
      add(1'b1, 1'b0, 1'b1, O_IDLE0);
      add(1'b1, 1'b0, 1'b1, O_B);
`else
      add(1'b1, 1'b0, 1'b1, O_B);
      add(1'b1, 1'b0, 1'b1, O_B);
`endif
      // Tie after idle goes to B when A owned last, then B holds HOLD cycles
      add(1'b0, 1'b0, 1'b0, O_IDLE0);
      add(1'b1, 1'b1, 1'b0, O_A);
      add(1'b1, 1'b0, 1'b0, O_IDLE0);
      add(1'b1, 1'b1, 1'b1, O_B);
      for (int i = 0; i < 3; i++) add(1'b1, 1'b1, 1'b1, O_B);
`ifdef MUX2_ARB_GAP_EN
      add(1'b1, 1'b1, 1'b1, O_IDLE1);
`endif
      add(1'b1, 1'b1, 1'b1, O_A);

      foreach (vecs[i]) begin
         step(vecs[i].rst_l, vecs[i].req_a, vecs[i].req_b);
         check("vec", i, vecs[i].exp);
      end

      // Mid-grant reset: B owns, reset drops it with SEL back to A, A then wins the tie
      step(1'b0, 1'b0, 1'b0);
      check("mr_rst", 0, O_IDLE0);
      step(1'b1, 1'b0, 1'b1);
      check("mr_own_b", 1, O_B);
      step(1'b1, 1'b1, 1'b1);
      check("mr_hold_b", 2, O_B);
      step(1'b0, 1'b1, 1'b1);
      check("mr_drop", 3, O_IDLE0);
      step(1'b1, 1'b1, 1'b1);
      check("mr_tie_a", 4, O_A);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

`default_nettype wire
